// File: rtl/decade_ring_check.sv
// decade_ring_check: consumer/checker for a 2-of-5 buffer-ring decade counter.
// Decodes the sampled ring to BCD and one-hot, tracks the counter with a
// private model stepped by the same clear/advance strobes, flags illegal or
// out-of-sequence codes, and pulses a carry on every 9->0 advance.
module decade_ring_check #(
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_ring,
  input  logic       i_clear,
  input  logic       i_advance,
  output logic [3:0] o_digit,
  output logic [9:0] o_onehot,
  output logic       o_code_ok,
  output logic       o_sync,
  output logic       o_err_code,
  output logic       o_err_seq,
  output logic       o_carry
);

  // Ring codes {a,b,c,d,e} for each digit.
  localparam logic [4:0] RING_0 = 5'b00011;
  localparam logic [4:0] RING_1 = 5'b10010;
  localparam logic [4:0] RING_2 = 5'b10001;
  localparam logic [4:0] RING_3 = 5'b01001;
  localparam logic [4:0] RING_4 = 5'b11000;
  localparam logic [4:0] RING_5 = 5'b10100;
  localparam logic [4:0] RING_6 = 5'b01100;
  localparam logic [4:0] RING_7 = 5'b01010;
  localparam logic [4:0] RING_8 = 5'b00110;
  localparam logic [4:0] RING_9 = 5'b00101;

  localparam logic [3:0] DIGIT_BAD = 4'hF;

  typedef enum logic {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_e;

  // Next ring code in counting order; an illegal code restarts at 0.
  function automatic logic [4:0] ring_succ(input logic [4:0] code);
    logic [4:0] nxt;
    case (code)
      RING_0:  nxt = RING_1;
      RING_1:  nxt = RING_2;
      RING_2:  nxt = RING_3;
      RING_3:  nxt = RING_4;
      RING_4:  nxt = RING_5;
      RING_5:  nxt = RING_6;
      RING_6:  nxt = RING_7;
      RING_7:  nxt = RING_8;
      RING_8:  nxt = RING_9;
      RING_9:  nxt = RING_0;
      default: nxt = RING_0;
    endcase
    return nxt;
  endfunction

  // Ring code to BCD; every code without exactly two bits set maps to F.
  function automatic logic [3:0] ring_to_digit(input logic [4:0] code);
    logic [3:0] dig;
    case (code)
      RING_0:  dig = 4'd0;
      RING_1:  dig = 4'd1;
      RING_2:  dig = 4'd2;
      RING_3:  dig = 4'd3;
      RING_4:  dig = 4'd4;
      RING_5:  dig = 4'd5;
      RING_6:  dig = 4'd6;
      RING_7:  dig = 4'd7;
      RING_8:  dig = 4'd8;
      RING_9:  dig = 4'd9;
      default: dig = DIGIT_BAD;
    endcase
    return dig;
  endfunction

  state_e     state_q, state_d;
  logic [4:0] exp_q, exp_d;
  logic       last_clear_q, last_advance_q;
  logic       clr_edge, adv_edge;

  logic [3:0] dec_digit;
  logic       dec_ok;
  logic [9:0] dec_onehot;

  logic [3:0] digit_q;
  logic [9:0] onehot_q;
  logic       code_ok_q;

  logic       bad_code, bad_seq;
  logic       err_code_q, err_code_d;
  logic       err_seq_q, err_seq_d;
  logic       carry_arm_q, carry_arm_d;
  logic       carry_q, carry_d;

  // Rising-edge detect on the strobes and step the expected-ring model.
  always_comb begin
    clr_edge = i_clear & ~last_clear_q;
    adv_edge = i_advance & ~last_advance_q;
    exp_d    = exp_q;
    if (clr_edge) begin
      exp_d = RING_0;
    end else if (adv_edge) begin
      exp_d = ring_succ(exp_q);
    end
  end

  // Decode the raw ring independently of tracking state.
  always_comb begin
    dec_digit  = ring_to_digit(i_ring);
    dec_ok     = (dec_digit != DIGIT_BAD);
    dec_onehot = '0;
    if (dec_ok) begin
      dec_onehot = 10'd1 << dec_digit;
    end
  end

  // Tracking state, error flags and carry pipeline next-state.
  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = TRACK;
    end

    bad_code = (state_q == TRACK) & ~dec_ok;
    bad_seq  = (state_q == TRACK) & (i_ring != exp_q);

    // Sticky flags are wiped by a clear edge, but an error detected in the
    // same cycle still lands because it is OR-ed in after the wipe.
    if (ERR_STICKY) begin
      err_code_d = (clr_edge ? 1'b0 : err_code_q) | bad_code;
      err_seq_d  = (clr_edge ? 1'b0 : err_seq_q) | bad_seq;
    end else begin
      err_code_d = bad_code;
      err_seq_d  = bad_seq;
    end

    // Two stages so the pulse lines up with the 0 digit on the decode outputs.
    carry_arm_d = adv_edge & ~clr_edge & (exp_q == RING_9) & (state_q == TRACK);
    carry_d     = carry_arm_q;
  end

  // Edge-detect history and expected-ring model registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_clear_q   <= 1'b1;
      last_advance_q <= 1'b1;
      exp_q          <= RING_0;
    end else begin
      last_clear_q   <= i_clear;
      last_advance_q <= i_advance;
      exp_q          <= exp_d;
    end
  end

  // Registered decode outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      digit_q   <= DIGIT_BAD;
      onehot_q  <= '0;
      code_ok_q <= 1'b0;
    end else begin
      digit_q   <= dec_digit;
      onehot_q  <= dec_onehot;
      code_ok_q <= dec_ok;
    end
  end

  // Checker FSM with its registered error and carry outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= UNSYNC;
      err_code_q  <= 1'b0;
      err_seq_q   <= 1'b0;
      carry_arm_q <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_seq_q   <= err_seq_d;
      carry_arm_q <= carry_arm_d;
      carry_q     <= carry_d;
    end
  end

  assign o_digit    = digit_q;
  assign o_onehot   = onehot_q;
  assign o_code_ok  = code_ok_q;
  assign o_sync     = (state_q == TRACK);
  assign o_err_code = err_code_q;
  assign o_err_seq  = err_seq_q;
  assign o_carry    = carry_q;

endmodule

// File: tb/tb_decade_ring_check.sv
// Directed bench for decade_ring_check: the bench plays the ring counter,
// runs a sticky and a pulse-mode checker side by side, and checks outputs
// through a one-deep expectation queue.
module tb_decade_ring_check;

  logic       clk;
  logic       i_reset;
  logic [4:0] i_ring;
  logic       i_clear;
  logic       i_advance;

  logic [3:0] s_digit, p_digit;
  logic [9:0] s_onehot, p_onehot;
  logic       s_ok, p_ok, s_sync, p_sync;
  logic       s_ec, p_ec, s_es, p_es, s_carry, p_carry;

  int errors = 0;
  int checks = 0;

  logic [4:0] code_tab [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                                5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  typedef struct {
    string      tag;
    logic [3:0] digit;
    logic [9:0] onehot;
    logic       ok;
    logic       sync;
    logic       carry;
    logic [1:0] ec;   // [1] sticky instance, [0] pulse instance
    logic [1:0] es;
  } exp_t;

  exp_t sb[$];

  decade_ring_check #(.ERR_STICKY(1'b1)) u_s (
    .i_clk(clk), .i_reset(i_reset), .i_ring(i_ring), .i_clear(i_clear),
    .i_advance(i_advance), .o_digit(s_digit), .o_onehot(s_onehot),
    .o_code_ok(s_ok), .o_sync(s_sync), .o_err_code(s_ec), .o_err_seq(s_es),
    .o_carry(s_carry)
  );

  decade_ring_check #(.ERR_STICKY(1'b0)) u_p (
    .i_clk(clk), .i_reset(i_reset), .i_ring(i_ring), .i_clear(i_clear),
    .i_advance(i_advance), .o_digit(p_digit), .o_onehot(p_onehot),
    .o_code_ok(p_ok), .o_sync(p_sync), .o_err_code(p_ec), .o_err_seq(p_es),
    .o_carry(p_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ring_digit(input logic [4:0] r);
    for (int i = 0; i < 10; i++) begin
      if (code_tab[i] == r) return i;
    end
    return 15;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare(input exp_t e);
    chk({e.tag, ".s_digit"},  16'(s_digit),  16'(e.digit));
    chk({e.tag, ".p_digit"},  16'(p_digit),  16'(e.digit));
    chk({e.tag, ".s_onehot"}, 16'(s_onehot), 16'(e.onehot));
    chk({e.tag, ".p_onehot"}, 16'(p_onehot), 16'(e.onehot));
    chk({e.tag, ".code_ok"},  16'(s_ok),     16'(e.ok));
    chk({e.tag, ".p_code_ok"}, 16'(p_ok),    16'(e.ok));
    chk({e.tag, ".sync"},     16'(s_sync),   16'(e.sync));
    chk({e.tag, ".p_sync"},   16'(p_sync),   16'(e.sync));
    chk({e.tag, ".carry"},    16'(s_carry),  16'(e.carry));
    chk({e.tag, ".p_carry"},  16'(p_carry),  16'(e.carry));
    chk({e.tag, ".s_err_code"}, 16'(s_ec),   16'(e.ec[1]));
    chk({e.tag, ".p_err_code"}, 16'(p_ec),   16'(e.ec[0]));
    chk({e.tag, ".s_err_seq"},  16'(s_es),   16'(e.es[1]));
    chk({e.tag, ".p_err_seq"},  16'(p_es),   16'(e.es[0]));
  endtask

  task automatic check_reset_values(input string tag);
    exp_t e;
    e.tag = tag; e.digit = 4'hF; e.onehot = '0; e.ok = 1'b0; e.sync = 1'b0;
    e.carry = 1'b0; e.ec = 2'b00; e.es = 2'b00;
    compare(e);
  endtask

  // One counter cycle: drive inputs, queue the outputs they must produce
  // after the next edge, then compare against the head of the queue.
  task automatic cyc(input logic [4:0] ring, input logic clr, input logic adv,
                     input logic sync, input logic carry,
                     input logic [1:0] ec, input logic [1:0] es, input string tag);
    exp_t e;
    int   d;
    i_ring    = ring;
    i_clear   = clr;
    i_advance = adv;
    d = ring_digit(ring);
    e.tag    = tag;
    e.digit  = 4'(d);
    e.onehot = (d == 15) ? 10'd0 : 10'(1 << d);
    e.ok     = (d != 15);
    e.sync   = sync;
    e.carry  = carry;
    e.ec     = ec;
    e.es     = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(sb.pop_front());
  endtask

  // One advance pulse (high one cycle, low one cycle) from digit cur.
  task automatic pulse(input int cur);
    cyc(code_tab[cur], 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, $sformatf("adv_hi_%0d", cur));
    cyc(code_tab[(cur + 1) % 10], 1'b0, 1'b0, 1'b1, (cur == 9), 2'b00, 2'b00,
        $sformatf("adv_lo_%0d", cur));
  endtask

  initial begin
    i_reset   = 1'b0;
    i_clear   = 1'b1;
    i_advance = 1'b0;
    i_ring    = 5'b00011;
    #1 i_reset = 1'b1;
    #1 check_reset_values("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1 i_reset = 1'b0;

    // Clear already high at reset release is not an edge.
    cyc(5'b00011, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "clr_held");
    cyc(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "clr_low");
    cyc(5'b00011, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clr_edge");
    cyc(5'b00011, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "tracking_0");

    // Full decade: 1..9 then 0 with a single carry.
    for (int d = 0; d < 10; d++) pulse(d);
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "carry_gone");

    // Up to 9, then clear and advance together: no carry.
    for (int d = 0; d < 9; d++) pulse(d);
    cyc(code_tab[9], 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "clradv_at9");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clradv_a");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clradv_b");

    // Wrong-but-legal code at digit 4, then illegal code, then clear.
    for (int d = 0; d < 4; d++) pulse(d);
    cyc(5'b01100, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, "seq_6_at_4");
    cyc(code_tab[4], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, "seq_hold_a");
    cyc(code_tab[4], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, "seq_hold_b");
    cyc(5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, "illegal_00111");
    cyc(code_tab[4], 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clr_clears");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "post_clr");

    // Error arriving in the clear-edge cycle wins over the wipe.
    cyc(5'b01100, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11, "seq_again");
    cyc(5'b11100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b11, "clr_err_wins");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, "sticky_after");
    cyc(code_tab[0], 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clr2");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "clean");

    // Reset mid-count at digit 7.
    for (int d = 0; d < 7; d++) pulse(d);
    #2 i_reset = 1'b1;
    #1 check_reset_values("reset_mid");
    #2 i_reset = 1'b0;
    cyc(5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "unsync_illegal");
    cyc(5'b01100, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "unsync_wrong");
    cyc(5'b01100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "resync");
    cyc(code_tab[0], 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, "resync_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
